muldiv_hilo: RTL and testbench

Iterative multi-cycle multiply/divide unit owning the architectural HI/LO registers. It is the producer side of the HI/LO result pair that the combinational datapath ALU cannot complete in a single cycle. It accepts MULT/MULTU/DIV/DIVU from the EX stage and holds busy while it iterates. It serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/muldiv_hilo_pkg.sv | 22 ++
 rtl/muldiv_hilo_if.sv | 29 ++
 rtl/muldiv_hilo_sign_fix.sv | 44 ++++
 rtl/muldiv_hilo.sv | 167 ++++++++++++++++
 tb/tb_muldiv_hilo.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_hilo_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the fixed divide-by-zero quotient.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_RUN  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   localparam logic [31:0] DIV0_QUOT     = 32'hFFFF_FFFF;
   localparam int          DEFAULT_ITERS = 32;

endpackage

// File: rtl/muldiv_hilo_if.sv
// EX-stage request / HI-LO access bundle for muldiv_hilo. The master is the
// pipeline side, the slave is the multiply/divide unit.
interface muldiv_hilo_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             start;
   op_t              op;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, x, y, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, x, y, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_hilo_sign_fix.sv
// Combinational sign helper: operand magnitudes for the prep step and
// conditional two's-complement negation of product, quotient and remainder.
module muldiv_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   a_mag,
   output logic [WIDTH-1:0]   b_mag,
   input  logic               sign_q,
   input  logic               sign_r,
   input  logic [2*WIDTH-1:0] prod,
   input  logic [WIDTH-1:0]   quo,
   input  logic [WIDTH-1:0]   rem,
   output logic [2*WIDTH-1:0] prod_fix,
   output logic [WIDTH-1:0]   quo_fix,
   output logic [WIDTH-1:0]   rem_fix
);
   localparam int W2 = 2 * WIDTH;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] v);
      return ~v + W2'(1);
   endfunction

   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;

   // The most negative operand maps onto itself, which is the correct
   // unsigned magnitude 2^(WIDTH-1).
   always_comb begin
      a_s      = a;
      b_s      = b;
      a_mag    = (is_signed && a_s < 0) ? neg_w(a) : a;
      b_mag    = (is_signed && b_s < 0) ? neg_w(b) : b;
      prod_fix = sign_q ? neg_w2(prod) : prod;
      quo_fix  = sign_q ? neg_w(quo)   : quo;
      rem_fix  = sign_r ? neg_w(rem)   : rem;
   end
endmodule

// File: rtl/muldiv_hilo.sv
// Iterative radix-2 multiply/divide unit owning HI/LO. Optional single-cycle
// multiply path enabled by defining MULDIV_FAST_MUL_EN.
module muldiv_hilo
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITERS = WIDTH
) (
   input  logic clk,
   input  logic rst,
   muldiv_hilo_if.slave bus
);
   localparam int CNT_W = $clog2(ITERS + 1);

   state_t             state_q, state_d;
   op_t                op_q;
   logic [WIDTH-1:0]   x_q, y_q;
   logic [WIDTH-1:0]   acc_q, mplier_q, mcand_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               sign_q, sign_r;
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic               is_div, is_signed;
   logic [WIDTH-1:0]   x_mag, y_mag;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   res_hi, res_lo;

   assign is_div    = op_q[1];
   assign is_signed = ~op_q[0];

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
      .is_signed (is_signed),
      .a         (x_q),
      .b         (y_q),
      .a_mag     (x_mag),
      .b_mag     (y_mag),
      .sign_q    (sign_q),
      .sign_r    (sign_r),
      .prod      ({acc_q, mplier_q}),
      .quo       (mplier_q),
      .rem       (acc_q),
      .prod_fix  (prod_fix),
      .quo_fix   (quo_fix),
      .rem_fix   (rem_fix)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_PREP;
`ifdef MULDIV_FAST_MUL_EN
         ST_PREP: state_d = is_div ? ST_RUN : ST_FIX;
`else
         ST_PREP: state_d = ST_RUN;
`endif
         ST_RUN:  if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_q != ST_IDLE);
      bus.done = (state_q == ST_FIX);
   end

   // Multiply: {acc, mplier} shifts right one bit per step with the
   // conditional add landing in acc. Divide: acc is the partial remainder,
   // mplier shifts the dividend out and the quotient bits in.
   always_comb begin
      mul_sum   = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
      div_shift = {acc_q, mplier_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, mcand_q});
      div_diff  = div_shift - {1'b0, mcand_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= OP_MULT;
         x_q      <= '0;
         y_q      <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         mcand_q  <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  op_q <= bus.op;
                  x_q  <= bus.x;
                  y_q  <= bus.y;
               end
            end
            ST_PREP: begin
               sign_q <= is_signed & (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
               sign_r <= is_signed & x_q[WIDTH-1];
               cnt_q  <= CNT_W'(ITERS);
               acc_q  <= '0;
               if (is_div) begin
                  mplier_q <= x_mag;
                  mcand_q  <= y_mag;
               end else begin
                  mplier_q <= y_mag;
                  mcand_q  <= x_mag;
`ifdef MULDIV_FAST_MUL_EN
                  {acc_q, mplier_q} <= {{WIDTH{1'b0}}, x_mag} * {{WIDTH{1'b0}}, y_mag};
`endif
               end
            end
            ST_RUN: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (is_div) begin
                  acc_q    <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                  mplier_q <= {mplier_q[WIDTH-2:0], div_ge};
               end else begin
                  acc_q    <= mul_sum[WIDTH:1];
                  mplier_q <= {mul_sum[0], mplier_q[WIDTH-1:1]};
               end
            end
            default: ;
         endcase
      end
   end

   // Divide by zero bypasses the iterated values entirely.
   always_comb begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
      if (is_div) begin
         if (y_q == '0) begin
            res_hi = x_q;
            res_lo = WIDTH'(DIV0_QUOT);
         end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
         end
      end
   end

   // An op result at done takes priority over a same-edge MTHI/MTLO.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (state_q == ST_FIX) begin
         hi_q <= res_hi;
         lo_q <= res_lo;
      end else begin
         if (bus.hi_we) hi_q <= bus.wdata;
         if (bus.lo_we) lo_q <= bus.wdata;
      end
   end

   assign bus.hi = hi_q;
   assign bus.lo = lo_q;
endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo: scoreboard of expected HI/LO and latency
// per launched op; also honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_hilo;
   import muldiv_pkg::*;

   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = DEFAULT_ITERS + 2;
`endif
   localparam int DIV_LAT = DEFAULT_ITERS + 2;

   typedef struct {
      string       tag;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;

   muldiv_hilo_if #(.WIDTH(W)) bus ();
   muldiv_hilo #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input op_t op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sbv, q, m;
      logic [63:0] ua, ub, r;
      sa  = {{32{a[31]}}, a};
      sbv = {{32{b[31]}}, b};
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      case (op)
         OP_MULT:  r = sa * sbv;
         OP_MULTU: r = ua * ub;
         default: begin
            if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
            else if (op == OP_DIV) begin
               q = sa / sbv;
               m = sa % sbv;
               r = {m[31:0], q[31:0]};
            end else begin
               r = {(ua % ub), 32'h0} | (ua / ub);
            end
         end
      endcase
      return r;
   endfunction

   // Returns at the negedge following the accept edge (the PREP cycle).
   task automatic launch(input op_t op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.x     = a;
      bus.y     = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.x     = $urandom;
      bus.y     = $urandom;
   endtask

   task automatic push(input string tag, input op_t op, input logic [31:0] ehi, input logic [31:0] elo);
      exp_t e;
      e.tag = tag;
      e.hi  = ehi;
      e.lo  = elo;
      e.lat = op[1] ? DIV_LAT : MUL_LAT;
      sb.push_back(e);
   endtask

   task automatic wait_done(input int n0);
      int   n;
      exp_t e;
      n = n0;
      while (bus.done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      check({e.tag, "_lat"}, 64'(n), 64'(e.lat));
      check({e.tag, "_busy_at_done"}, 64'(bus.busy), 64'(1));
      @(negedge clk);
      check({e.tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
      check({e.tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
      check({e.tag, "_idle"}, 64'({bus.busy, bus.done}), 64'(0));
   endtask

   task automatic run_op(input string tag, input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
      launch(op, a, b);
      push(tag, op, ehi, elo);
      wait_done(1);
   endtask

   initial begin
      int   d0;
      op_t  rop;
      logic [31:0] ra, rb;
      logic [63:0] mr;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = OP_MULT;
      bus.x     = '0;
      bus.y     = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wdata = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(bus.busy), 64'(0));
      check("reset_done", 64'(bus.done), 64'(0));
      check("reset_hilo", {bus.hi, bus.lo}, 64'(0));
      rst = 1'b0;

      run_op("mult_neg2x3", OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_100_7",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
      run_op("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
      run_op("divu_by0",    OP_DIVU,  32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF);
      run_op("div_by0",     OP_DIV,   32'hFFFF_FFF0, 32'h0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);

      for (int i = 0; i < 8; i++) begin
         rop = op_t'(i % 4);
         ra  = $urandom;
         rb  = (i >= 4) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (i == 3) ra = -ra;
         mr  = model(rop, ra, rb);
         launch(rop, ra, rb);
         push($sformatf("rand%0d", i), rop, mr[63:32], mr[31:0]);
         wait_done(1);
      end

      // Second start while busy is dropped; MTLO while busy is later overwritten.
      d0 = done_cnt;
      launch(OP_DIVU, 32'd100, 32'd7);
      push("busy_first_op", OP_DIVU, 32'd2, 32'd14);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MULT;
      bus.x     = 32'd5;
      bus.y     = 32'd6;
      @(negedge clk);
      bus.start = 1'b0;
      bus.lo_we = 1'b1;
      bus.wdata = 32'h0000_AAAA;
      @(negedge clk);
      bus.lo_we = 1'b0;
      check("mtlo_while_busy", 64'(bus.lo), 64'(32'h0000_AAAA));
      wait_done(4);
      repeat (40) @(negedge clk);
      check("single_done", 64'(done_cnt - d0), 64'(1));

      bus.hi_we = 1'b1;
      bus.wdata = 32'h0000_5555;
      @(negedge clk);
      bus.hi_we = 1'b0;
      check("mthi_idle_hi", 64'(bus.hi), 64'(32'h0000_5555));
      check("mthi_idle_lo", 64'(bus.lo), 64'(32'd14));

      // Abort in RUN cycle 10.
      launch(OP_MULTU, 32'd7, 32'd9);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 64'(bus.busy), 64'(0));
      check("abort_done", 64'(bus.done), 64'(0));
      check("abort_hilo", {bus.hi, bus.lo}, 64'(0));
      d0 = done_cnt;
      repeat (40) @(negedge clk);
      check("abort_no_done", 64'(done_cnt - d0), 64'(0));
      run_op("after_abort", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
